// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start detection, 2-of-3 majority bit voting,
// configurable 5..8 data bits, optional parity, one checked stop bit, break detect.
module uart_rx_framer #(
  parameter int OSR = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       CE,
  input  logic       RXD,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PAR     = 3'd3,
    S_STOP    = 3'd4,
    S_BRKWAIT = 3'd5
  } state_t;

  localparam logic [4:0] PH_LAST = 5'(OSR - 1);
  localparam logic [4:0] PH_S0   = 5'(OSR / 2 - 1);
  localparam logic [4:0] PH_S1   = 5'(OSR / 2);
  localparam logic [4:0] PH_DEC  = 5'(OSR / 2 + 1);

  state_t     state_q, state_d;
  logic [4:0] phase_q;
  logic [2:0] bitcnt_q;
  logic       s0_q, s1_q;
  logic [7:0] data_q;
  logic       par_q;
  logic [1:0] wls_q;
  logic       pen_q, eps_q, sp_q;

  logic maj, at_dec, at_last, last_bit;
  logic finish, start_frame;
  logic pe_c, fe_c, bi_c;

  // The third vote is the live RXD on the decision tick itself.
  assign maj      = (s0_q & s1_q) | (s0_q & RXD) | (s1_q & RXD);
  assign at_dec   = CE && (phase_q == PH_DEC);
  assign at_last  = CE && (phase_q == PH_LAST);
  assign last_bit = (bitcnt_q == ({1'b0, wls_q} + 3'd4));

  assign pe_c = pen_q && (sp_q ? (par_q != ~eps_q)
                               : ((^data_q ^ par_q) != ~eps_q));
  assign fe_c = ~maj;
  assign bi_c = (data_q == 8'h00) && !(pen_q && par_q) && !maj;

  assign STATE = state_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    finish      = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      S_IDLE:    if (CE && !RXD) state_d = S_START;
      S_START: begin
        if (at_dec && maj) state_d = S_IDLE;
        else if (at_last) begin
          state_d     = S_DATA;
          start_frame = 1'b1;
        end
      end
      S_DATA:    if (at_last && last_bit) state_d = pen_q ? S_PAR : S_STOP;
      S_PAR:     if (at_last) state_d = S_STOP;
      // Leave at the decision tick so a back-to-back start edge is not missed.
      S_STOP: begin
        if (at_dec) begin
          finish  = 1'b1;
          state_d = bi_c ? S_BRKWAIT : S_IDLE;
        end
      end
      S_BRKWAIT: if (CE && RXD) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      phase_q    <= 5'd0;
      bitcnt_q   <= 3'd0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      data_q     <= 8'h00;
      par_q      <= 1'b0;
      wls_q      <= 2'b00;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      DOUT       <= 8'h00;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
    end else begin
      RXFINISHED <= finish;
      if (CE) begin
        if (state_q == S_IDLE || state_d == S_IDLE || state_d == S_BRKWAIT)
          phase_q <= 5'd0;
        else
          phase_q <= (phase_q == PH_LAST) ? 5'd0 : phase_q + 5'd1;
        if (phase_q == PH_S0) s0_q <= RXD;
        if (phase_q == PH_S1) s1_q <= RXD;
        if (state_q == S_DATA && phase_q == PH_DEC) data_q[bitcnt_q] <= maj;
        if (state_q == S_PAR && phase_q == PH_DEC)  par_q <= maj;
        if (start_frame) begin
          data_q   <= 8'h00;
          par_q    <= 1'b0;
          bitcnt_q <= 3'd0;
          wls_q    <= WLS;
          pen_q    <= PEN;
          eps_q    <= EPS;
          sp_q     <= SP;
        end else if (state_q == S_DATA && phase_q == PH_LAST) begin
          bitcnt_q <= bitcnt_q + 3'd1;
        end
        if (finish) begin
          DOUT <= data_q;
          PE   <= pe_c;
          FE   <= fe_c | bi_c;
          BI   <= bi_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: frames are driven tick by tick and every
// RXFINISHED pulse is scored against an expected {BI,FE,PE,DOUT} queue.
module tb_uart_rx_framer;

  localparam int W = 11;

  logic       CLK = 1'b0;
  logic       RSTN, CE, RXD, PEN, EPS, SP;
  logic [1:0] WLS;
  logic [7:0] DOUT;
  logic       PE, FE, BI, RXFINISHED;
  logic [2:0] STATE;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  uart_rx_framer #(.OSR(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .RXD(RXD), .WLS(WLS), .PEN(PEN),
    .EPS(EPS), .SP(SP), .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI),
    .RXFINISHED(RXFINISHED), .STATE(STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // scoreboard: every pulse must match the head of the expected queue
  always @(negedge CLK) begin
    if (RXFINISHED === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check("extra_pulse", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("frame", {21'd0, BI, FE, PE, DOUT}, {21'd0, e});
      end
    end
  end

  // drivers (all start and end on a falling edge)
  task automatic tick(input logic v);
    RXD = v;
    CE  = 1'b1;
    @(negedge CLK);
    CE  = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_bit(input logic v);
    repeat (16) tick(v);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                            input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic expect_frame(input logic [W-1:0] v);
    exp_q.push_back(v);
    exp_pulses++;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"}, {24'd0, DOUT}, 32'h00);
    check({tag, "_flags"}, {29'd0, PE, FE, BI}, 32'd0);
    check({tag, "_fin"}, {31'd0, RXFINISHED}, 32'd0);
    check({tag, "_state"}, {29'd0, STATE}, 32'd0);
  endtask

  task automatic cfg_8n1();
    WLS = 2'b11; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; CE = 1'b0; RXD = 1'b1;
    cfg_8n1();
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RSTN = 1'b1;

    // CE low: a low RXD must not start a frame
    RXD = 1'b0;
    repeat (10) @(negedge CLK);
    check("ce_low_state", {29'd0, STATE}, 32'd0);
    idle_bits(1);

    // 8N1 0xA5
    expect_frame(11'h0A5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);

    // 5 bits, even parity, wrong parity bit
    WLS = 2'b00; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
    expect_frame(11'h116);
    send_frame(8'h16, 5, 1'b1, 1'b0, 1'b1);
    idle_bits(1);

    // 7 bits, stick parity with EPS=0 expects a 1 parity bit
    WLS = 2'b10; PEN = 1'b1; EPS = 1'b0; SP = 1'b1;
    expect_frame(11'h07F);
    send_frame(8'h7F, 7, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    cfg_8n1();
    check("pulses_a", pulse_cnt, exp_pulses);

    // 3-tick glitch is a false start
    repeat (3) tick(1'b0);
    idle_bits(1);
    check("glitch_state", {29'd0, STATE}, 32'd0);
    check("glitch_pulses", pulse_cnt, exp_pulses);

    // back-to-back frames
    expect_frame(11'h055);
    expect_frame(11'h00F);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check("b2b_pulses", pulse_cnt, exp_pulses);

    // stop bit low with nonzero data: framing error only
    expect_frame(11'h281);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
    idle_bits(2);
    check("fe_pulses", pulse_cnt, exp_pulses);

    // reset during data bit 4 of 0x3C
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    repeat (8) tick(1'b1);
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    check_outputs_zero("midrst");
    RSTN = 1'b1;
    idle_bits(2);
    check("midrst_pulses", pulse_cnt, exp_pulses);
    expect_frame(11'h03C);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check("rx3c_pulses", pulse_cnt, exp_pulses);

    // break: 20 bit times low
    expect_frame(11'h600);
    repeat (20) send_bit(1'b0);
    check("brk_pulses", pulse_cnt, exp_pulses);
    check("brk_state", {29'd0, STATE}, 32'd5);
    idle_bits(1);
    check("brk_exit_state", {29'd0, STATE}, 32'd0);
    check("pending", exp_q.size(), 32'd0);
    check("final_pulses", pulse_cnt, exp_pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter OSR, default 16: baud-enable ticks per bit period; legal values 8..32.
REQ-002 SHALL have port CLK  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RSTN  input  1: synchronous active-low reset, sampled on the CLK rising edge.
REQ-004 SHALL have port CE  input  1: oversampling tick, OSR pulses per bit period, each one CLK wide.
REQ-005 SHALL have port RXD  input  1: serial data, already two-flop synchronised upstream; idle level 1.
REQ-006 SHALL have port WLS  input  2: word length; 00=5, 01=6, 10=7, 11=8 data bits.
REQ-007 SHALL have port PEN  input  1: parity bit present.
REQ-008 SHALL have port EPS  input  1: 1=even parity, 0=odd parity.
REQ-009 SHALL have port SP  input  1: stick parity; when PEN=1, the parity bit SHALL equal ~EPS.
REQ-010 SHALL have port DOUT  output  8: received word, LSB first on the line, upper unused bits zero.
REQ-011 SHALL have port PE  output  1: parity error flag for the current DOUT.
REQ-012 SHALL have port FE  output  1: framing error (first stop bit sampled 0).
REQ-013 SHALL have port BI  output  1: break (data, parity and stop bits all 0).
REQ-014 SHALL have port RXFINISHED  output  1: one-CLK pulse when DOUT, PE, FE and BI are updated.

Function
REQ-015 SHALL keep a bit-phase counter 0..OSR-1 that advances only on CE and wraps to 0.
REQ-016 SHALL, within each bit, sample RXD on the CE ticks at phase OSR/2-1, OSR/2 and OSR/2+1, and take the 2-of-3 majority as the bit value.
REQ-017 SHALL implement states IDLE, START, DATA, PAR, STOP and BRKWAIT.
REQ-018 IDLE: on a CE with RXD=0, SHALL go to START with phase=0; otherwise remain in IDLE.
REQ-019 START: at the majority decision (phase OSR/2+1), value 1 SHALL return to IDLE with no output change (false start); value 0 SHALL continue to phase OSR-1 and then go to DATA.
REQ-020 DATA: SHALL shift in WLS+5 bits LSB first, each spanning OSR ticks, then go to PAR if PEN=1, else to STOP.
REQ-021 PAR: SHALL sample one bit for OSR ticks, then go to STOP.
REQ-022 STOP: at the decision phase SHALL latch outputs and pulse RXFINISHED in the same cycle.
REQ-023 STOP exit: SHALL go to BRKWAIT if BI is set, else to IDLE; there is no wait for the end of the stop bit, so back-to-back frames resynchronise.
REQ-024 BRKWAIT: SHALL remain there until a CE with RXD=1, then go to IDLE.
REQ-025 Parity check, SP=0: PE=1 when XOR(data bits, parity bit) != ~EPS, i.e. even parity requires an XOR of 0; PE=0 when PEN=0.
REQ-026 Parity check, SP=1: PE=1 when the parity bit != ~EPS.
REQ-027 Stop check: FE=1 when the stop-bit majority is 0; a second stop bit, if any, SHALL NOT be checked.
REQ-028 Break check: BI=1 when all data bits, the parity bit (if PEN) and the stop bit are 0; BI=1 SHALL also force FE=1.
REQ-029 DOUT, PE, FE and BI SHALL hold their values until the next RXFINISHED.
REQ-030 WLS, PEN, EPS and SP SHALL be sampled when leaving START and held for the rest of the frame.
REQ-031 With CE=0, no state, counter or output SHALL change.

Reset
REQ-032 With RSTN=0 at a CLK edge: state=IDLE, phase=0, bit count=0, DOUT=8'h00, PE=FE=BI=0, RXFINISHED=0.
REQ-033 Reset SHALL take effect mid-frame without a pulse on RXFINISHED; after release, the next frame SHALL be received only from a fresh RXD falling edge seen in IDLE.

Verification
REQ-034 OSR=16, 8N1, send 0xA5 -> one RXFINISHED pulse, DOUT=0xA5, PE=FE=BI=0.
REQ-035 WLS=00, PEN=1, EPS=1, send 5'b10110 with a wrong parity bit of 0 -> DOUT=0x16, PE=1.
REQ-036 A 3-tick low glitch on idle RXD -> no RXFINISHED, state returns to IDLE.
REQ-037 Hold RXD=0 for 20 bit times, 8N1 -> DOUT=0x00, BI=1, FE=1, a single pulse, no further frame until RXD=1.
REQ-038 Two 8N1 frames back-to-back, 0x55 then 0x0F -> two pulses, values in order, no FE.
REQ-039 Assert RSTN=0 during data bit 4 -> all outputs zero, no pulse; the next full frame 0x3C is received correctly.
